// File: rtl/axis_event_serializer_if.sv
// Bus bundle for the event serializer: valid-only 128-bit event input and
// 32-bit AXI4-Stream output toward the DMA writer.
interface axis_event_serializer_if;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;

  // master: the serializer itself (drives the AXI4-Stream output)
  modport master (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast
  );

  // slave: the environment (event source and stream sink)
  modport slave (
    output s_axis_tdata,
    output s_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast
  );
endinterface

// File: rtl/axis_event_serializer.sv
// Buffers 128-bit coincidence events in a small FIFO and emits each one as four
// 32-bit AXI4-Stream beats, with optional empty-hit filtering and status counters.
module axis_event_serializer #(
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cfg_filter,
  axis_event_serializer_if.master bus,
  output logic [31:0]             sts_events,
  output logic [31:0]             sts_drops
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned AW    = FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned HIT_W = 66;

  logic [127:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [1:0]       r_beat;
  logic [31:0]      r_events;
  logic [31:0]      r_drops;

  logic             w_empty;
  logic             w_full;
  logic             w_xfer;
  logic             w_pop;
  logic             w_qual;
  logic             w_push;
  logic             w_drop;
  logic [127:0]     w_head;
  logic [31:0]      w_beat_data;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_xfer  = ~w_empty & bus.m_axis_tready;
  assign w_pop   = w_xfer & (r_beat == 2'd3);

  // A full FIFO still accepts an event when the head's last beat leaves this cycle
  assign w_qual  = bus.s_axis_tvalid &
                   ~(cfg_filter & (bus.s_axis_tdata[HIT_W-1:0] == HIT_W'(0)));
  assign w_push  = w_qual & (~w_full | w_pop);
  assign w_drop  = w_qual & ~w_push;

  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_comb begin
    w_beat_data = w_head[31:0];
    case (r_beat)
      2'd0:    w_beat_data = w_head[31:0];
      2'd1:    w_beat_data = w_head[63:32];
      2'd2:    w_beat_data = w_head[95:64];
      default: w_beat_data = w_head[127:96];
    endcase
  end

  // Event storage carries no reset; it is only observed while tvalid is high
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.s_axis_tdata;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_beat   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_xfer) begin
        r_beat <= r_beat + 2'd1;
      end
    end
  end

  // Saturating status counters
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_events <= '0;
      r_drops  <= '0;
    end else begin
      if (w_push && (r_events != 32'hFFFF_FFFF)) begin
        r_events <= r_events + 32'd1;
      end
      if (w_drop && (r_drops != 32'hFFFF_FFFF)) begin
        r_drops <= r_drops + 32'd1;
      end
    end
  end

  assign bus.m_axis_tvalid = ~w_empty;
  assign bus.m_axis_tdata  = w_beat_data;
  assign bus.m_axis_tlast  = ~w_empty & (r_beat == 2'd3);
  assign sts_events        = r_events;
  assign sts_drops         = r_drops;

endmodule

// File: tb/tb_axis_event_serializer.sv
// Directed and randomized bench for axis_event_serializer; the reference model
// keeps the outstanding output as a queue of 32-bit beats.
module tb_axis_event_serializer;

  localparam int unsigned DEPTH_LOG2 = 2;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

  logic        aclk;
  logic        areset;
  logic        cfg_filter;
  logic [31:0] sts_events;
  logic [31:0] sts_drops;

  axis_event_serializer_if u_if ();

  axis_event_serializer #(.FIFO_DEPTH_LOG2(DEPTH_LOG2)) u_dut (
    .aclk       (aclk),
    .areset     (areset),
    .cfg_filter (cfg_filter),
    .bus        (u_if),
    .sts_events (sts_events),
    .sts_drops  (sts_drops)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] q[$];
  logic [31:0] m_events;
  logic [31:0] m_drops;
  int          beats_seen;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd_event();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Compare every visible output against the beat-queue model
  task automatic check_outputs();
    chk("tvalid", 128'(u_if.m_axis_tvalid), 128'(q.size() != 0));
    if (q.size() != 0) begin
      chk("tdata", 128'(u_if.m_axis_tdata), 128'(q[0]));
      chk("tlast", 128'(u_if.m_axis_tlast), 128'((q.size() % 4) == 1));
    end else begin
      chk("tlast_idle", 128'(u_if.m_axis_tlast), 128'(0));
    end
    chk("sts_events", 128'(sts_events), 128'(m_events));
    chk("sts_drops", 128'(sts_drops), 128'(m_drops));
  endtask

  // One clock: the model decides transfer/push from pre-edge state, then checks after the edge
  task automatic step();
    logic         xfer;
    logic         pop_last;
    logic         full;
    logic         qual;
    logic         push;
    logic [127:0] ev;
    xfer     = (q.size() != 0) && u_if.m_axis_tready;
    pop_last = xfer && ((q.size() % 4) == 1);
    full     = ((q.size() + 3) / 4) == DEPTH;
    ev       = u_if.s_axis_tdata;
    qual     = u_if.s_axis_tvalid && !(cfg_filter && (ev[65:0] == 66'd0));
    push     = qual && (!full || pop_last);
    if (u_if.m_axis_tvalid && u_if.m_axis_tready) beats_seen++;
    @(posedge aclk);
    #1;
    if (xfer) void'(q.pop_front());
    if (push) begin
      for (int k = 0; k < 4; k++) q.push_back(ev[32*k +: 32]);
      if (m_events != 32'hFFFF_FFFF) m_events++;
    end else if (qual) begin
      if (m_drops != 32'hFFFF_FFFF) m_drops++;
    end
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    areset = 1'b1;
    #1;
    q.delete();
    m_events = '0;
    m_drops  = '0;
    chk("rst_tvalid", 128'(u_if.m_axis_tvalid), 128'(0));
    chk("rst_tlast", 128'(u_if.m_axis_tlast), 128'(0));
    chk("rst_events", 128'(sts_events), 128'(0));
    chk("rst_drops", 128'(sts_drops), 128'(0));
    repeat (cycles) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [127:0] d);
    u_if.s_axis_tvalid = v;
    u_if.s_axis_tdata  = d;
  endtask

  initial begin
    logic [127:0] ev;
    int           budget;
    areset             = 1'b0;
    cfg_filter         = 1'b0;
    u_if.s_axis_tvalid = 1'b0;
    u_if.s_axis_tdata  = '0;
    u_if.m_axis_tready = 1'b0;
    m_events           = '0;
    m_drops            = '0;
    beats_seen         = 0;
    #2;

    // Reset and idle
    do_reset(3);
    repeat (3) step();

    // Single event, tready high
    u_if.m_axis_tready = 1'b1;
    drive(1'b1, 128'h0000000F_0000000E_0000000D_0000000C);
    step();
    chk("single_beat0", 128'(u_if.m_axis_tdata), 128'(32'h0000000C));
    drive(1'b0, '0);
    repeat (5) step();
    chk("single_events", 128'(sts_events), 128'(1));

    // Overflow with tready low, then drain
    do_reset(2);
    u_if.m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ev = rnd_event();
      ev[0] = 1'b1;
      drive(1'b1, ev);
      step();
    end
    drive(1'b0, '0);
    chk("ovf_events", 128'(sts_events), 128'(4));
    chk("ovf_drops", 128'(sts_drops), 128'(2));
    u_if.m_axis_tready = 1'b1;
    beats_seen = 0;
    repeat (20) step();
    chk("ovf_beats", 128'(beats_seen), 128'(16));

    // Push into a full FIFO on the cycle the head's last beat leaves
    do_reset(2);
    u_if.m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, rnd_event() | 128'd1);
      step();
    end
    drive(1'b0, '0);
    u_if.m_axis_tready = 1'b1;
    repeat (3) step();
    drive(1'b1, rnd_event() | 128'd1);
    step();
    drive(1'b0, '0);
    chk("simul_events", 128'(sts_events), 128'(5));
    chk("simul_drops", 128'(sts_drops), 128'(0));
    repeat (20) step();

    // Filter: empty hit field discarded, bit 65 set forwarded
    do_reset(2);
    cfg_filter = 1'b1;
    ev = rnd_event();
    ev[65:0] = 66'd0;
    ev[127] = 1'b1;
    drive(1'b1, ev);
    step();
    drive(1'b0, '0);
    step();
    chk("filt_drop_valid", 128'(u_if.m_axis_tvalid), 128'(0));
    chk("filt_drop_events", 128'(sts_events), 128'(0));
    ev[65] = 1'b1;
    drive(1'b1, ev);
    step();
    drive(1'b0, '0);
    chk("filt_pass_events", 128'(sts_events), 128'(1));
    repeat (5) step();
    cfg_filter = 1'b0;

    // Randomized back-pressure, reset after beat 1 of an event
    do_reset(2);
    drive(1'b1, rnd_event());
    step();
    drive(1'b0, '0);
    beats_seen = 0;
    budget = 0;
    while (q.size() > 2 && budget < 60) begin
      u_if.m_axis_tready = 1'($urandom_range(0, 1));
      step();
      budget++;
    end
    chk("midrst_reached_beat2", 128'(q.size()), 128'(2));
    u_if.m_axis_tready = 1'($urandom_range(0, 1));
    do_reset(2);
    ev = rnd_event();
    drive(1'b1, ev);
    step();
    drive(1'b0, '0);
    chk("midrst_beat0", 128'(u_if.m_axis_tdata), 128'(ev[31:0]));
    repeat (10) begin
      u_if.m_axis_tready = 1'($urandom_range(0, 1));
      step();
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      u_if.m_axis_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) cfg_filter = ~cfg_filter;
      ev = rnd_event();
      if ($urandom_range(0, 3) == 0) ev[65:0] = 66'd0;
      drive(($urandom_range(0, 2) == 0), ev);
      step();
    end
    drive(1'b0, '0);
    u_if.m_axis_tready = 1'b1;
    repeat (24) step();
    chk("final_empty", 128'(u_if.m_axis_tvalid), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
